// File: rtl/r_pkg.sv
// rtl/r_pkg.sv - shared types and constants for the router port reader
package r_pkg;

  localparam int ROUTER_SOFT_RST_CYCLES = 30;

  typedef struct packed {
    logic [5:0] len;
    logic [1:0] addr;
  } r_hdr_t;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    PARITY,
    DROP
  } rd_state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic       err;
  } r_beat_t;

endpackage

// File: rtl/r_skid_fifo.sv
// rtl/r_skid_fifo.sv - shift-register skid FIFO; head entry drives the stream directly from flops
module r_skid_fifo
  import r_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  r_beat_t                push_beat,
  input  logic                   pop,
  output r_beat_t                head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] free_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  r_beat_t        slot     [DEPTH];
  r_beat_t        slot_nxt [DEPTH];
  logic [CW-1:0]  count;
  logic [CW-1:0]  count_nxt;
  logic           do_push;
  logic           do_pop;
  logic [AW-1:0]  wr_idx;

  assign do_pop   = pop && !empty;
  // A pop frees the slot this cycle, so a push into a full FIFO is accepted alongside it
  assign do_push  = push && (!full || do_pop);
  assign wr_idx   = AW'(count - CW'(do_pop));
  assign head     = slot[0];
  assign free_cnt = CW'(DEPTH) - count;

  always_comb begin
    slot_nxt  = slot;
    count_nxt = count;
    if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        slot_nxt[i] = slot[i+1];
      end
      slot_nxt[DEPTH-1] = '0;
      count_nxt = count_nxt - CW'(1);
    end
    if (do_push) begin
      slot_nxt[wr_idx] = push_beat;
      count_nxt = count_nxt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot[i] <= '0;
      end
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      slot  <= slot_nxt;
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/r_port_reader.sv
// rtl/r_port_reader.sv - drains one router output port into a framed, parity-checked byte stream
module r_port_reader
  import r_pkg::*;
#(
  parameter int SKID_DEPTH  = 4,
  parameter int STALL_LIMIT = 24,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             vld_out,
  input  logic [7:0]       data_out,
  output logic             read_enb,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_data,
  output logic             m_sop,
  output logic             m_eop,
  output logic             m_err,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int CW = $clog2(SKID_DEPTH) + 1;
  localparam int STALL_MAX = (STALL_LIMIT < ROUTER_SOFT_RST_CYCLES) ? STALL_LIMIT
                                                                    : ROUTER_SOFT_RST_CYCLES - 1;
  localparam int SW = $clog2(STALL_MAX + 1);

  rd_state_e     state;
  logic          rd_pend;
  logic [6:0]    remaining;
  logic [7:0]    acc;
  logic [SW-1:0] stall_cnt;
  logic          stall_hit;
  logic          mismatch;
  r_hdr_t        hdr;
  logic          push;
  r_beat_t       push_beat;
  r_beat_t       head;
  logic          skid_full;
  logic          skid_empty;
  logic [CW-1:0] free_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign hdr      = r_hdr_t'(data_out);
  assign mismatch = (data_out != acc);

  // The read in flight already owns a skid slot, so it is subtracted from the free count
  always_comb begin
    read_enb = 1'b0;
    if (!resetn && vld_out) begin
      if (state == DROP) read_enb = (remaining > 7'(rd_pend));
      else               read_enb = (free_cnt > CW'(rd_pend));
    end
  end

  assign stall_hit = vld_out && !read_enb && (stall_cnt == SW'(STALL_MAX - 1)) &&
                     (state == PAYLOAD || state == PARITY);

  always_comb begin
    push      = 1'b0;
    push_beat = '0;
    if (rd_pend) begin
      case (state)
        HEADER:  begin push = 1'b1; push_beat = '{data: data_out, sop: 1'b1, eop: 1'b0, err: 1'b0}; end
        PAYLOAD: begin push = 1'b1; push_beat = '{data: data_out, sop: 1'b0, eop: 1'b0, err: 1'b0}; end
        PARITY:  begin push = 1'b1; push_beat = '{data: data_out, sop: 1'b0, eop: 1'b1, err: mismatch}; end
        default: ;
      endcase
    end else if (state == DROP && remaining == '0 && !skid_full) begin
      push      = 1'b1;
      push_beat = '{data: 8'h00, sop: 1'b0, eop: 1'b1, err: 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state     <= IDLE;
      rd_pend   <= 1'b0;
      remaining <= '0;
      acc       <= '0;
      stall_cnt <= '0;
      pkt_count <= '0;
      err_count <= '0;
    end else begin
      rd_pend <= read_enb;
      if (read_enb || state == IDLE)
        stall_cnt <= '0;
      else if (vld_out && stall_cnt != SW'(STALL_MAX))
        stall_cnt <= stall_cnt + SW'(1);

      case (state)
        IDLE: if (read_enb) state <= HEADER;
        HEADER: if (rd_pend) begin
          remaining <= {1'b0, hdr.len} + 7'd1;
          acc       <= hdr;
          state     <= (hdr.len == '0) ? PARITY : PAYLOAD;
        end
        PAYLOAD: if (rd_pend) begin
          acc       <= acc ^ data_out;
          remaining <= remaining - 7'd1;
          if (remaining == 7'd2) state <= PARITY;
        end else if (stall_hit) begin
          state <= DROP;
        end
        PARITY: if (rd_pend) begin
          remaining <= '0;
          // A header read issued on the same cycle as the parity capture belongs to the next packet
          state     <= read_enb ? HEADER : IDLE;
          if (mismatch) err_count <= sat_inc(err_count);
          else          pkt_count <= sat_inc(pkt_count);
        end else if (stall_hit) begin
          state <= DROP;
        end
        DROP: if (rd_pend) begin
          remaining <= remaining - 7'd1;
        end else if (remaining == '0 && !skid_full) begin
          state     <= IDLE;
          err_count <= sat_inc(err_count);
        end
        default: state <= IDLE;
      endcase
    end
  end

  r_skid_fifo #(.DEPTH(SKID_DEPTH)) u_skid (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_beat (push_beat),
    .pop       (m_ready),
    .head      (head),
    .full      (skid_full),
    .empty     (skid_empty),
    .free_cnt  (free_cnt)
  );

  assign m_valid = !skid_empty;
  assign m_data  = head.data;
  assign m_sop   = head.sop;
  assign m_eop   = head.eop;
  assign m_err   = head.err;

endmodule

// File: tb/tb_r_port_reader.sv
// tb/tb_r_port_reader.sv - randomized scoreboard bench for r_port_reader against a router FIFO model
module tb_r_port_reader;

  localparam int STALL_LIMIT = 24;
  localparam int CNT_W       = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic       err;
  } tb_beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             resetn;
  logic             vld_out;
  logic [7:0]       data_out;
  logic             read_enb;
  logic             m_valid;
  logic             m_ready;
  logic [7:0]       m_data;
  logic             m_sop;
  logic             m_eop;
  logic             m_err;
  logic [CNT_W-1:0] pkt_count;
  logic [CNT_W-1:0] err_count;

  r_port_reader #(.SKID_DEPTH(4), .STALL_LIMIT(STALL_LIMIT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .vld_out   (vld_out),
    .data_out  (data_out),
    .read_enb  (read_enb),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_sop     (m_sop),
    .m_eop     (m_eop),
    .m_err     (m_err),
    .pkt_count (pkt_count),
    .err_count (err_count)
  );

  tb_beat_t   exp_q[$];
  logic [7:0] rfifo[$];
  logic [7:0] wq[$];
  logic [7:0] pl[$];
  int vectors = 0;
  int miscompares = 0;
  int exp_pkt = 0;
  int exp_err = 0;
  int wr_pct = 100;
  int rdy_pct = 100;
  int rstall = 0;
  int rstall_max = 0;
  logic re_s = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every accepted stream beat is popped against the scoreboard
  tb_beat_t mon_e;
  always @(negedge clk) begin
    if (resetn === 1'b0 && m_valid === 1'b1 && m_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_beat: got data 0x%0h sop %b eop %b err %b, expected no beat",
                 m_data, m_sop, m_eop, m_err);
      end else begin
        mon_e = exp_q.pop_front();
        check("beat", {m_data, m_sop, m_eop, m_err}, mon_e);
      end
    end
  end

  // One router cycle: sample read strobe, serve the read one cycle later, let the writer refill
  task automatic tick();
    @(negedge clk);
    re_s = read_enb;
    if (vld_out && !re_s) rstall++;
    else rstall = 0;
    if (rstall > rstall_max) rstall_max = rstall;
    @(posedge clk);
    #1;
    if (re_s) begin
      check("read_nonempty", 32'(rfifo.size() != 0), 1);
      if (rfifo.size() != 0) data_out = rfifo.pop_front();
    end
    if (wq.size() != 0 && $urandom_range(99) < wr_pct) rfifo.push_back(wq.pop_front());
    vld_out = (rfifo.size() != 0);
    m_ready = ($urandom_range(99) < rdy_pct);
  endtask

  task automatic send_raw(input logic [7:0] hdr, input logic [7:0] pay[$], input logic [7:0] par,
                          input bit model);
    logic [7:0] x;
    x = hdr;
    wq.push_back(hdr);
    if (model) exp_q.push_back(tb_beat_t'{hdr, 1'b1, 1'b0, 1'b0});
    foreach (pay[i]) begin
      x ^= pay[i];
      wq.push_back(pay[i]);
      if (model) exp_q.push_back(tb_beat_t'{pay[i], 1'b0, 1'b0, 1'b0});
    end
    wq.push_back(par);
    if (model) begin
      exp_q.push_back(tb_beat_t'{par, 1'b0, 1'b1, par != x});
      if (par != x) exp_err++;
      else exp_pkt++;
    end
  endtask

  task automatic send_rand(input bit corrupt);
    logic [5:0] len;
    logic [7:0] h, x, par;
    len = 6'($urandom_range(63));
    h = {len, 2'($urandom_range(3))};
    x = h;
    pl.delete();
    for (int i = 0; i < int'(len); i++) begin
      pl.push_back(8'($urandom_range(255)));
      x ^= pl[i];
    end
    par = corrupt ? 8'($urandom_range(255)) : x;
    send_raw(h, pl, par, 1'b1);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || wq.size() != 0 || rfifo.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check({name, "_drained"}, 32'(n < budget), 1);
    repeat (3) tick();
  endtask

  task automatic check_counts(input string name);
    check({name, "_pkt_count"}, 32'(pkt_count), exp_pkt);
    check({name, "_err_count"}, 32'(err_count), exp_err);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_m_valid"}, 32'(m_valid), 0);
    check({name, "_sop_eop_err"}, {m_sop, m_eop, m_err}, 0);
    check({name, "_m_data"}, 32'(m_data), 0);
    check({name, "_pkt_count"}, 32'(pkt_count), 0);
    check({name, "_err_count"}, 32'(err_count), 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit got;
    resetn   = 1'b1;
    vld_out  = 1'b0;
    data_out = 8'h00;
    m_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b0;
    check_reset_outputs("reset");
    check("reset_read_enb", 32'(read_enb), 0);

    // Good packet: header 0D, payload 11 22 33, parity 0D
    pl.delete(); pl.push_back(8'h11); pl.push_back(8'h22); pl.push_back(8'h33);
    send_raw(8'h0D, pl, 8'h0D, 1'b1);
    drain("good_pkt", 200);
    check("good_pkt_count", 32'(pkt_count), 1);
    check_counts("good_pkt");

    // Same packet with a wrong parity byte
    send_raw(8'h0D, pl, 8'hFF, 1'b1);
    drain("bad_parity", 200);
    check("bad_parity_err_count", 32'(err_count), 1);
    check_counts("bad_parity");

    // Zero-length packet
    pl.delete();
    send_raw(8'h02, pl, 8'h02, 1'b1);
    drain("zero_len", 200);
    check_counts("zero_len");

    // len 63 with back-pressure for 10 cycles mid-packet
    pl.delete();
    for (int i = 0; i < 63; i++) pl.push_back(8'($urandom_range(255)));
    begin
      logic [7:0] x;
      x = 8'hFC;
      foreach (pl[i]) x ^= pl[i];
      send_raw(8'hFC, pl, x, 1'b1);
    end
    repeat (20) tick();
    rstall_max = 0;
    rdy_pct = 0;
    repeat (10) tick();
    check("backpressure_read_blocked", 32'(re_s), 0);
    check("backpressure_router_has_data", 32'(vld_out), 1);
    rdy_pct = 100;
    n = 0;
    got = 0;
    while (!got && n < 4) begin
      tick();
      got = re_s;
      n++;
    end
    check("backpressure_read_resumes", 32'(got), 1);
    drain("len63", 600);
    check("len63_no_guard", 32'(rstall_max < STALL_LIMIT), 1);
    check_counts("len63");

    // len 20 with m_ready held low: stall guard forces a drop
    rdy_pct = 0;
    m_ready = 1'b0;
    pl.delete();
    for (int i = 0; i < 20; i++) pl.push_back(8'($urandom_range(255)));
    send_raw({6'd20, 2'd2}, pl, 8'h00, 1'b0);
    exp_q.push_back(tb_beat_t'{{6'd20, 2'd2}, 1'b1, 1'b0, 1'b0});
    for (int i = 0; i < 3; i++) exp_q.push_back(tb_beat_t'{pl[i], 1'b0, 1'b0, 1'b0});
    exp_q.push_back(tb_beat_t'{8'h00, 1'b0, 1'b1, 1'b1});
    exp_err++;
    rstall_max = 0;
    repeat (70) tick();
    check("drop_router_drained", rfifo.size() + wq.size(), 0);
    check("drop_err_before_release", 32'(err_count), exp_err - 1);
    check("drop_stall_cycles", rstall_max, STALL_LIMIT);
    rdy_pct = 100;
    drain("drop", 200);
    check_counts("drop");

    // Reset mid-payload
    pl.delete();
    for (int i = 0; i < 10; i++) pl.push_back(8'($urandom_range(255)));
    begin
      logic [7:0] x;
      x = {6'd10, 2'd3};
      foreach (pl[i]) x ^= pl[i];
      send_raw({6'd10, 2'd3}, pl, x, 1'b1);
    end
    repeat (6) tick();
    resetn = 1'b1;
    #1;
    check("midreset_read_enb", 32'(read_enb), 0);
    rfifo.delete();
    wq.delete();
    exp_q.delete();
    exp_pkt = 0;
    exp_err = 0;
    vld_out = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b0;
    check_reset_outputs("midreset");
    pl.delete(); pl.push_back(8'hA5);
    send_raw(8'h05, pl, 8'h05 ^ 8'hA5, 1'b1);
    drain("after_reset", 200);
    check_counts("after_reset");

    // Randomized batches with writer gaps and random back-pressure
    rdy_pct = 75;
    for (int b = 0; b < 10; b++) begin
      wr_pct = $urandom_range(50, 100);
      for (int k = 0; k < 4; k++) send_rand($urandom_range(3) == 0);
      drain("random", 3000);
    end
    check_counts("random_final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
